// File: rtl/overflow_interval_builder_if.sv
// Store-overflow input bus and interval-buffer write port of overflow_interval_builder.
interface overflow_interval_builder_if;
  logic        ovf_valid_i;
  logic [31:0] ovf_addr_i;
  logic [1:0]  ovf_size_i;
  logic        flush_i;
  logic        en_write_o;
  logic [31:0] addr_first_o;
  logic [31:0] addr_last_o;
  logic        open_o;
  logic [15:0] interval_count_o;

  modport master (
    output ovf_valid_i, ovf_addr_i, ovf_size_i, flush_i,
    input  en_write_o, addr_first_o, addr_last_o, open_o, interval_count_o
  );

  modport slave (
    input  ovf_valid_i, ovf_addr_i, ovf_size_i, flush_i,
    output en_write_o, addr_first_o, addr_last_o, open_o, interval_count_o
  );
endinterface

// File: rtl/overflow_interval_builder.sv
// Merges flagged overflowing stores into contiguous [first, last] intervals and
// writes each closed interval to the downstream interval buffer.
//
// state | meaning
// IDLE  | no interval open
// OPEN  | first_q / last_q / idle_cnt_q track the live interval
// DRAIN | a closed interval waits in pend_*_q and is emitted this cycle
module overflow_interval_builder #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  overflow_interval_builder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OPEN, DRAIN} state_e;

  state_e      state_q;
  logic [31:0] first_q, last_q, pend_first_q, pend_last_q;
  logic [15:0] idle_cnt_q;
  logic        en_write_q;
  logic [31:0] addr_first_q, addr_last_q;
  logic [15:0] count_q;

  logic [32:0] end_wide;
  logic [31:0] store_end, merged_last;
  logic [32:0] last_p1;
  logic        contig, timeout_hit;
  logic        emit_w;
  logic [31:0] emit_first_w, emit_last_w;

  // Extent computed at 33 bits so a store touching the top of memory saturates.
  assign end_wide    = {1'b0, bus.ovf_addr_i} + (33'd1 << bus.ovf_size_i) - 33'd1;
  assign store_end   = end_wide[32] ? 32'hFFFF_FFFF : end_wide[31:0];
  assign last_p1     = {1'b0, last_q} + 33'd1;
  assign contig      = (bus.ovf_addr_i >= first_q) && ({1'b0, bus.ovf_addr_i} <= last_p1);
  assign merged_last = (store_end > last_q) ? store_end : last_q;
  assign timeout_hit = (idle_cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    emit_w       = 1'b0;
    emit_first_w = first_q;
    emit_last_w  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ovf_valid_i && bus.flush_i) begin
          emit_w       = 1'b1;
          emit_first_w = bus.ovf_addr_i;
          emit_last_w  = store_end;
        end
      end
      OPEN: begin
        if (bus.ovf_valid_i && contig) begin
          emit_w      = bus.flush_i;
          emit_last_w = merged_last;
        end else if (bus.ovf_valid_i) begin
          emit_w = 1'b1;
        end else begin
          emit_w = bus.flush_i || timeout_hit;
        end
      end
      DRAIN: begin
        emit_w       = 1'b1;
        emit_first_w = pend_first_q;
        emit_last_w  = pend_last_q;
      end
      default: emit_w = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      first_q      <= '0;
      last_q       <= '0;
      pend_first_q <= '0;
      pend_last_q  <= '0;
      idle_cnt_q   <= '0;
      en_write_q   <= 1'b0;
      addr_first_q <= '0;
      addr_last_q  <= '0;
      count_q      <= '0;
    end else begin
      en_write_q <= emit_w;
      if (emit_w) begin
        addr_first_q <= emit_first_w;
        addr_last_q  <= emit_last_w;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.ovf_valid_i) begin
            first_q    <= bus.ovf_addr_i;
            last_q     <= store_end;
            idle_cnt_q <= '0;
            if (!bus.flush_i) state_q <= OPEN;
          end
        end
        OPEN: begin
          if (bus.ovf_valid_i && contig) begin
            idle_cnt_q <= '0;
            if (bus.flush_i) state_q <= IDLE;
            else             last_q  <= merged_last;
          end else if (bus.ovf_valid_i) begin
            idle_cnt_q <= '0;
            if (bus.flush_i) begin
              pend_first_q <= bus.ovf_addr_i;
              pend_last_q  <= store_end;
              state_q      <= DRAIN;
            end else begin
              first_q <= bus.ovf_addr_i;
              last_q  <= store_end;
            end
          end else if (bus.flush_i || timeout_hit) begin
            idle_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
          end
        end
        DRAIN: begin
          if (bus.ovf_valid_i && bus.flush_i) begin
            pend_first_q <= bus.ovf_addr_i;
            pend_last_q  <= store_end;
          end else if (bus.ovf_valid_i) begin
            first_q    <= bus.ovf_addr_i;
            last_q     <= store_end;
            idle_cnt_q <= '0;
            state_q    <= OPEN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.en_write_o       = en_write_q;
  assign bus.addr_first_o     = addr_first_q;
  assign bus.addr_last_o      = addr_last_q;
  assign bus.open_o           = (state_q == OPEN);
  assign bus.interval_count_o = count_q;

endmodule

// File: tb/tb_overflow_interval_builder.sv
// Directed bench for overflow_interval_builder with TIMEOUT = 16.
module tb_overflow_interval_builder;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses;

  overflow_interval_builder_if ifc ();

  overflow_interval_builder #(.TIMEOUT(16)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (ifc.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, return just after the rising edge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [1:0] s, input logic f);
    @(negedge clk_i);
    ifc.ovf_valid_i = v;
    ifc.ovf_addr_i  = a;
    ifc.ovf_size_i  = s;
    ifc.flush_i     = f;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_pulse(input string tag, input logic [31:0] f, input logic [31:0] l,
                             input logic [31:0] cnt);
    check({tag, ".en"},    32'(ifc.en_write_o), 32'd1);
    check({tag, ".first"}, ifc.addr_first_o, f);
    check({tag, ".last"},  ifc.addr_last_o, l);
    check({tag, ".count"}, 32'(ifc.interval_count_o), cnt);
  endtask

  task automatic idle_n(input int n);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 32'h0, 2'd0, 1'b0);
      if (ifc.en_write_o) pulses++;
    end
  endtask

  initial begin
    ifc.ovf_valid_i = 1'b0;
    ifc.ovf_addr_i  = '0;
    ifc.ovf_size_i  = '0;
    ifc.flush_i     = 1'b0;
    #22;
    check("rst.en",    32'(ifc.en_write_o), 32'd0);
    check("rst.first", ifc.addr_first_o, 32'd0);
    check("rst.last",  ifc.addr_last_o, 32'd0);
    check("rst.open",  32'(ifc.open_o), 32'd0);
    check("rst.count", 32'(ifc.interval_count_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Contiguous run closed by timeout 16 cycles after the last store
    cyc(1'b1, 32'h1000, 2'd2, 1'b0);
    check("run.open", 32'(ifc.open_o), 32'd1);
    cyc(1'b1, 32'h1004, 2'd2, 1'b0);
    cyc(1'b1, 32'h1008, 2'd2, 1'b0);
    check("run.nopulse", 32'(ifc.en_write_o), 32'd0);
    idle_n(15);
    check("run.early_pulses", 32'(pulses), 32'd0);
    check("run.open_before_to", 32'(ifc.open_o), 32'd1);
    cyc(1'b0, 32'h0, 2'd0, 1'b0);
    check_pulse("run", 32'h1000, 32'h100B, 32'd1);
    check("run.open_after", 32'(ifc.open_o), 32'd0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0);
    check("run.pulse_width", 32'(ifc.en_write_o), 32'd0);
    check("run.hold_first", ifc.addr_first_o, 32'h1000);

    // Gap: second store closes the first interval, new one stays open
    cyc(1'b1, 32'h2000, 2'd0, 1'b0);
    cyc(1'b1, 32'h2010, 2'd0, 1'b0);
    check_pulse("gap1", 32'h2000, 32'h2000, 32'd2);
    check("gap.open", 32'(ifc.open_o), 32'd1);
    idle_n(15);
    check("gap.early_pulses", 32'(pulses), 32'd0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0);
    check_pulse("gap2", 32'h2010, 32'h2010, 32'd3);

    // Overlap keeps the larger last; flush emits
    cyc(1'b1, 32'h3000, 2'd3, 1'b0);
    cyc(1'b1, 32'h3002, 2'd0, 1'b0);
    check("ovl.nopulse", 32'(ifc.en_write_o), 32'd0);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    check_pulse("ovl", 32'h3000, 32'h3007, 32'd4);
    check("ovl.open", 32'(ifc.open_o), 32'd0);

    // Flush with a non-contiguous store: two back-to-back pulses
    cyc(1'b1, 32'h4000, 2'd2, 1'b0);
    cyc(1'b1, 32'h5000, 2'd2, 1'b1);
    check_pulse("fnc1", 32'h4000, 32'h4003, 32'd5);
    check("fnc.open_drain", 32'(ifc.open_o), 32'd0);
    cyc(1'b0, 32'h0, 2'd0, 1'b0);
    check_pulse("fnc2", 32'h5000, 32'h5003, 32'd6);
    cyc(1'b0, 32'h0, 2'd0, 1'b0);
    check("fnc.done", 32'(ifc.en_write_o), 32'd0);

    // Top-of-memory store saturates last
    cyc(1'b1, 32'hFFFF_FFFC, 2'd3, 1'b0);
    check("wrap.open", 32'(ifc.open_o), 32'd1);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    check_pulse("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd7);

    // Adjacent store merged together with flush in the same cycle
    cyc(1'b1, 32'h7000, 2'd0, 1'b0);
    cyc(1'b1, 32'h7001, 2'd1, 1'b1);
    check_pulse("adj", 32'h7000, 32'h7002, 32'd8);
    check("adj.open", 32'(ifc.open_o), 32'd0);

    // Descending store is not merged
    cyc(1'b1, 32'h8004, 2'd2, 1'b0);
    cyc(1'b1, 32'h8000, 2'd2, 1'b0);
    check_pulse("desc1", 32'h8004, 32'h8007, 32'd9);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    check_pulse("desc2", 32'h8000, 32'h8003, 32'd10);

    // Flush in IDLE alone does nothing
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    check("idleflush.en", 32'(ifc.en_write_o), 32'd0);
    check("idleflush.count", 32'(ifc.interval_count_o), 32'd10);

    // Asynchronous reset mid-interval discards it
    cyc(1'b1, 32'h6000, 2'd2, 1'b0);
    check("rstmid.open", 32'(ifc.open_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rstmid.open0",  32'(ifc.open_o), 32'd0);
    check("rstmid.count0", 32'(ifc.interval_count_o), 32'd0);
    check("rstmid.first0", ifc.addr_first_o, 32'd0);
    check("rstmid.last0",  ifc.addr_last_o, 32'd0);
    check("rstmid.en0",    32'(ifc.en_write_o), 32'd0);
    @(negedge clk_i);
    ifc.ovf_valid_i = 1'b0;
    rst_ni = 1'b1;
    idle_n(20);
    check("rstmid.no_pulse", 32'(pulses), 32'd0);
    check("rstmid.count", 32'(ifc.interval_count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
